fabric_tag_demux: RTL and testbench



---
 rtl/fabric_tag_demux_if.sv | 24 ++
 rtl/fabric_tag_demux.sv | 160 ++++++++++++++++
 tb/tb_fabric_tag_demux.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_tag_demux_if.sv
// Tagged input stream and per-output untagged streams of the tag demux.
// The fabric side (source of tagged words, sink of demuxed words) uses master.
interface fabric_tag_demux_if #(
  parameter int NUM_OUTPUTS = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 4
);
  logic                                   in_valid;
  logic                                   in_ready;
  logic [DATA_WIDTH+TAG_WIDTH-1:0]        in_data;
  logic [NUM_OUTPUTS-1:0]                 out_valid;
  logic [NUM_OUTPUTS-1:0]                 out_ready;
  logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fabric_tag_demux.sv
// Strips the tag from a {tag, value} stream and steers the value into a per-output
// FIFO selected by a static tag map; unmatched tags are drained, counted and flagged.
module fabric_tag_demux #(
  parameter  int NUM_OUTPUTS  = 2,
  parameter  int DATA_WIDTH   = 32,
  parameter  int TAG_WIDTH    = 4,
  parameter  int FIFO_DEPTH   = 2,
  localparam int CONFIG_WIDTH = NUM_OUTPUTS * (TAG_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fabric_tag_demux_if.slave       bus,
  input  logic [CONFIG_WIDTH-1:0] cfg_data,
  input  logic                    err_clear,
  output logic                    err_unmatched,
  output logic [15:0]             drop_count
);

  localparam int ENTRY_W = TAG_WIDTH + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int DEST_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  if (NUM_OUTPUTS < 1) begin : g_bad_num_outputs
    $fatal(1, "fabric_tag_demux: NUM_OUTPUTS must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $fatal(1, "fabric_tag_demux: DATA_WIDTH must be >= 1");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $fatal(1, "fabric_tag_demux: TAG_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 1) begin : g_bad_fifo_depth
    $fatal(1, "fabric_tag_demux: FIFO_DEPTH must be >= 1");
  end

  logic [TAG_WIDTH-1:0]   in_tag;
  logic [DATA_WIDTH-1:0]  in_value;
  logic [NUM_OUTPUTS-1:0] match;
  logic [NUM_OUTPUTS-1:0] full;
  logic [DEST_W-1:0]      dest;
  logic                   hit;
  logic                   accept;
  logic                   drop;

  assign in_tag   = bus.in_data[DATA_WIDTH +: TAG_WIDTH];
  assign in_value = bus.in_data[DATA_WIDTH-1:0];

  always_comb begin
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      match[k] = cfg_data[k*ENTRY_W + TAG_WIDTH] &&
                 (cfg_data[k*ENTRY_W +: TAG_WIDTH] == in_tag);
    end
  end

  // Lowest matching index wins; duplicate tags in the map are legal.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    dest = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (match[k] && !hit) begin
        hit  = 1'b1;
        dest = DEST_W'(k);
      end
    end
  end

  // Ready looks only at occupancy, never at out_ready, so there is no
  // combinational path from consumers back to the producer.
  assign bus.in_ready = hit ? !full[dest] : 1'b1;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drop         = bus.in_valid && !hit;

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push;
    logic                  pop;

    always_comb begin
      push     = accept && hit && (dest == DEST_W'(k));
      pop      = (count_q != '0) && bus.out_ready[k];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // NOTE: storage is not reset; count_q gates visibility, so stale contents are never observed.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_value;
      end
    end

    assign full[k]          = (count_q == CNT_W'(FIFO_DEPTH));
    assign bus.out_valid[k] = (count_q != '0);
    assign bus.out_data[k]  = mem_q[rd_ptr_q];
  end

  logic        err_q, err_d;
  logic [15:0] drop_count_q, drop_count_d;

  // A drop in the same cycle as err_clear wins and restarts the count at one.
  always_comb begin
    err_d        = err_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      err_d = 1'b1;
      if (err_clear) begin
        drop_count_d = 16'd1;
      end else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end else if (err_clear) begin
      err_d        = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q        <= 1'b0;
      drop_count_q <= '0;
    end else begin
      err_q        <= err_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign err_unmatched = err_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_fabric_tag_demux.sv
// Self-checking bench for fabric_tag_demux: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the tag map and FIFOs.
module tb_fabric_tag_demux;
  localparam int NO    = 2;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 2;
  localparam int CW    = NO * (TW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cfg_data;
  logic          err_clear;
  logic          err_unmatched;
  logic [15:0]   drop_count;

  fabric_tag_demux_if #(.NUM_OUTPUTS(NO), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  fabric_tag_demux #(
    .NUM_OUTPUTS(NO), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .cfg_data      (cfg_data),
    .err_clear     (err_clear),
    .err_unmatched (err_unmatched),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: one bounded queue per output, a sticky flag and a counter.
  logic [DW-1:0] q [NO][$];
  bit            exp_err;
  int            exp_cnt;
  bit            cfg_en  [NO];
  logic [TW-1:0] cfg_tag [NO];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] pack_cfg();
    logic [CW-1:0] p;
    p = '0;
    for (int k = 0; k < NO; k++) p[k*(TW+1) +: TW+1] = {cfg_en[k], cfg_tag[k]};
    return p;
  endfunction

  function automatic void set_cfg(input bit e0, input logic [TW-1:0] t0,
                                  input bit e1, input logic [TW-1:0] t1);
    cfg_en[0] = e0; cfg_tag[0] = t0;
    cfg_en[1] = e1; cfg_tag[1] = t1;
  endfunction

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic step(input bit v, input logic [TW-1:0] tag, input logic [DW-1:0] val,
                      input logic [NO-1:0] rdy, input bit ec, input bit chk, output bit acc);
    bit hit;
    int dest;
    bit exp_rdy;
    bus.in_valid  = v;
    bus.in_data   = {tag, val};
    bus.out_ready = rdy;
    err_clear     = ec;
    cfg_data      = pack_cfg();
    hit  = 1'b0;
    dest = 0;
    for (int k = 0; k < NO; k++) begin
      if (!hit && cfg_en[k] && cfg_tag[k] == tag) begin
        hit  = 1'b1;
        dest = k;
      end
    end
    exp_rdy = hit ? (q[dest].size() < DEPTH) : 1'b1;
    @(negedge clk);
    if (chk) begin
      check("in_ready", bus.in_ready, exp_rdy);
      for (int k = 0; k < NO; k++) begin
        check($sformatf("out_valid[%0d]", k), bus.out_valid[k], q[k].size() != 0);
        if (q[k].size() != 0) check($sformatf("out_data[%0d]", k), bus.out_data[k], q[k][0]);
      end
      check("err_unmatched", err_unmatched, exp_err);
      check("drop_count", drop_count, exp_cnt);
    end
    for (int k = 0; k < NO; k++) begin
      if (rdy[k] && q[k].size() != 0) void'(q[k].pop_front());
    end
    acc = v && exp_rdy;
    if (acc && hit) q[dest].push_back(val);
    if (v && !hit) begin
      exp_err = 1'b1;
      exp_cnt = ec ? 1 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
    end else if (ec) begin
      exp_err = 1'b0;
      exp_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [NO-1:0] rdy);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, 1'b0, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    int base;
    bit tgl;
    logic [NO-1:0] rdy;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    err_clear     = 1'b0;
    exp_err       = 1'b0;
    exp_cnt       = 0;
    set_cfg(1'b1, 4'd3, 1'b1, 4'd5);
    cfg_data = pack_cfg();

    #2;
    check("reset_out_valid", bus.out_valid, '0);
    check("reset_err", err_unmatched, 1'b0);
    check("reset_drop_count", drop_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic routing, one-cycle latency
    step(1'b1, 4'd5, 32'hDEADBEEF, 2'b11, 1'b0, 1'b1, acc);
    check("route_valid_tag5", bus.out_valid, 2'b10);
    check("route_data_tag5", bus.out_data[1], 32'hDEADBEEF);
    step(1'b1, 4'd3, 32'h1, 2'b11, 1'b0, 1'b1, acc);
    check("route_valid_tag3", bus.out_valid, 2'b01);
    check("route_data_tag3", bus.out_data[0], 32'h1);
    idle(2, 2'b11);

    // Backpressure: out0 fills, out1 unaffected, then drains in order
    step(1'b1, 4'd3, 32'hA, 2'b10, 1'b0, 1'b1, acc);
    step(1'b1, 4'd3, 32'hB, 2'b10, 1'b0, 1'b1, acc);
    step(1'b1, 4'd3, 32'hC, 2'b10, 1'b0, 1'b1, acc);
    check("bp_third_blocked", acc, 1'b0);
    step(1'b1, 4'd5, 32'h55, 2'b00, 1'b0, 1'b1, acc);
    check("bp_other_output_data", bus.out_data[1], 32'h55);
    check("bp_full_holds_a", bus.out_data[0], 32'hA);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) step(1'b1, 4'd3, 32'hC, 2'b11, 1'b0, 1'b1, acc);
    check("bp_c_accepted", acc, 1'b1);
    idle(4, 2'b11);

    // Unmatched drops and err_clear
    for (int i = 0; i < 4; i++) step(1'b1, 4'd7, DW'(i), 2'b11, 1'b0, 1'b1, acc);
    check("drop_err", err_unmatched, 1'b1);
    check("drop_count_4", drop_count, 16'd4);
    check("drop_no_valid", bus.out_valid, '0);
    step(1'b0, 4'd0, 32'h0, 2'b11, 1'b1, 1'b1, acc);
    check("clear_err", err_unmatched, 1'b0);
    check("clear_count", drop_count, 16'd0);
    step(1'b1, 4'd7, 32'h0, 2'b11, 1'b1, 1'b1, acc);
    check("clear_vs_drop_err", err_unmatched, 1'b1);
    check("clear_vs_drop_count", drop_count, 16'd1);

    // Priority and disable
    set_cfg(1'b1, 4'd3, 1'b1, 4'd3);
    step(1'b1, 4'd3, 32'h33, 2'b00, 1'b0, 1'b1, acc);
    check("prio_lowest_wins", bus.out_valid, 2'b01);
    idle(2, 2'b11);
    set_cfg(1'b0, 4'd3, 1'b1, 4'd3);
    step(1'b1, 4'd3, 32'h44, 2'b00, 1'b0, 1'b1, acc);
    check("prio_disabled_out0", bus.out_valid, 2'b10);
    idle(2, 2'b11);
    set_cfg(1'b0, 4'd3, 1'b0, 4'd3);
    step(1'b1, 4'd3, 32'h45, 2'b00, 1'b0, 1'b1, acc);
    check("prio_all_disabled", bus.out_valid, 2'b00);
    check("prio_drop_count", drop_count, 16'd2);
    idle(1, 2'b11);

    // Pointer wrap with simultaneous push/pop, out_ready[0] toggling
    set_cfg(1'b1, 4'd3, 1'b1, 4'd5);
    tgl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        step(1'b1, 4'd3, DW'(i), {1'b1, tgl}, 1'b0, 1'b1, acc);
        tgl = ~tgl;
      end
      check("wrap_accepted", acc, 1'b1);
    end
    idle(4, 2'b11);
    check("wrap_drained", bus.out_valid, '0);

    // Randomized traffic with occasional mid-stream config changes
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 63) begin
        for (int k = 0; k < NO; k++) begin
          cfg_tag[k] = TW'($urandom_range(2, 8));
          cfg_en[k]  = ($urandom_range(0, 3) != 0);
        end
      end
      rdy = NO'($urandom);
      step($urandom_range(0, 3) != 0, TW'($urandom_range(2, 8)), $urandom, rdy,
           $urandom_range(0, 15) == 0, 1'b1, acc);
    end
    idle(4, 2'b11);

    // Saturation of the drop counter
    set_cfg(1'b1, 4'd3, 1'b1, 4'd5);
    for (int i = 0; i < 65537; i++) step(1'b1, 4'd7, 32'h0, 2'b11, 1'b0, 1'b0, acc);
    check("sat_drop_count", drop_count, 16'hFFFF);
    step(1'b1, 4'd7, 32'h0, 2'b11, 1'b0, 1'b1, acc);
    check("sat_hold", drop_count, 16'hFFFF);

    // Asynchronous reset with two entries buffered in out0
    step(1'b1, 4'd3, 32'hA1, 2'b00, 1'b0, 1'b1, acc);
    step(1'b1, 4'd3, 32'hA2, 2'b00, 1'b0, 1'b1, acc);
    check("pre_reset_valid", bus.out_valid, 2'b01);
    bus.in_valid = 1'b1;
    bus.in_data  = {4'd3, 32'hA3};
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", bus.out_valid, '0);
    check("async_reset_err", err_unmatched, 1'b0);
    check("async_reset_count", drop_count, 16'd0);
    for (int k = 0; k < NO; k++) q[k].delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3, 2'b11);
    check("post_reset_no_stale", bus.out_valid, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
